// File: rtl/mic_dma_arbiter.sv
// mic_dma_arbiter
//   Round-robin arbiter sharing one Avalon-MM burst-write master port among
//   N_REQ microphone DMA channels. A channel owns the shared port for a whole
//   burst; only the owner sees the slave's waitrequest, everyone else is held
//   off with waitrequest=1. A software enable mask gates which channels may
//   win the next arbitration.
//
// Ports
//   CLK, RESET           system clock, asynchronous active-low reset
//   CH_ENABLE            per-channel eligibility mask
//   REQ_*                per-channel Avalon-MM burst-write masters (packed, ch i at slice i)
//   REQ_WAITREQUEST      per-channel waitrequest back to the channels
//   AM_*                 shared Avalon-MM burst-write master toward the slave
//   GRANT                one-hot owner of the shared port, 0 when idle
//   BUSY                 high while a burst is in progress
//
// State table
//   state    | meaning
//   ST_IDLE  | no owner; arbitrate among eligible channels starting at ptr
//   ST_BURST | owner gidx drives AM_*; leave after the last beat is accepted
module mic_dma_arbiter #(
  parameter int N_REQ   = 4,
  parameter int BURST_W = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       CH_ENABLE,
  input  logic [N_REQ*32-1:0]    REQ_ADDR,
  input  logic [N_REQ*BURST_W-1:0] REQ_BURSTCOUNT,
  input  logic [N_REQ-1:0]       REQ_WRITE,
  input  logic [N_REQ*32-1:0]    REQ_WRITEDATA,
  input  logic [N_REQ*4-1:0]     REQ_BYTEENABLE,
  output logic [N_REQ-1:0]       REQ_WAITREQUEST,
  output logic [31:0]            AM_ADDR,
  output logic [BURST_W-1:0]     AM_BURSTCOUNT,
  output logic                   AM_WRITE,
  output logic [31:0]            AM_WRITEDATA,
  output logic [3:0]             AM_BYTEENABLE,
  input  logic                   AM_WAITREQUEST,
  output logic [N_REQ-1:0]       GRANT,
  output logic                   BUSY
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [PTR_W-1:0]   gidx, gidx_nxt;
  logic [N_REQ-1:0]   grant, grant_nxt;
  logic [BURST_W-1:0] beats, beats_nxt;

  logic [N_REQ-1:0]   eligible;
  logic               found;
  logic [PTR_W-1:0]   sel_idx;
  logic [BURST_W-1:0] sel_bc;
  logic               accepted;

  // ptr + offs, wrapped at N_REQ rather than at the next power of two
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  assign eligible = REQ_WRITE & CH_ENABLE;

  // first eligible channel at or after ptr
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && eligible[wrap_add(ptr, k)]) begin
        found   = 1'b1;
        sel_idx = wrap_add(ptr, k);
      end
    end
  end

  always_comb begin
    sel_bc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == PTR_W'(i)) sel_bc = REQ_BURSTCOUNT[i*BURST_W +: BURST_W];
    end
  end

  // shared master mux; everything zero and all channels stalled when idle
  always_comb begin
    AM_ADDR         = '0;
    AM_BURSTCOUNT   = '0;
    AM_WRITE        = 1'b0;
    AM_WRITEDATA    = '0;
    AM_BYTEENABLE   = '0;
    REQ_WAITREQUEST = '1;
    if (state == ST_BURST) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gidx == PTR_W'(i)) begin
          AM_ADDR            = REQ_ADDR[i*32 +: 32];
          AM_BURSTCOUNT      = REQ_BURSTCOUNT[i*BURST_W +: BURST_W];
          AM_WRITE           = REQ_WRITE[i];
          AM_WRITEDATA       = REQ_WRITEDATA[i*32 +: 32];
          AM_BYTEENABLE      = REQ_BYTEENABLE[i*4 +: 4];
          REQ_WAITREQUEST[i] = AM_WAITREQUEST;
        end
      end
    end
  end

  assign accepted = (state == ST_BURST) && AM_WRITE && !AM_WAITREQUEST;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    grant_nxt = grant;
    beats_nxt = beats;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt          = ST_BURST;
          gidx_nxt           = sel_idx;
          grant_nxt          = '0;
          grant_nxt[sel_idx] = 1'b1;
          // a zero burstcount is treated as a single-beat burst
          beats_nxt          = (sel_bc == '0) ? BURST_W'(1) : sel_bc;
        end
      end
      ST_BURST: begin
        if (accepted) begin
          beats_nxt = beats - 1'b1;
          if (beats == BURST_W'(1)) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            ptr_nxt   = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
      ptr   <= '0;
      gidx  <= '0;
      grant <= '0;
      beats <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gidx  <= gidx_nxt;
      grant <= grant_nxt;
      beats <= beats_nxt;
    end
  end

  assign GRANT = grant;
  assign BUSY  = (state == ST_BURST);

endmodule

// File: tb/tb_mic_dma_arbiter.sv
module tb_mic_dma_arbiter;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [3:0]   CH_ENABLE;
  logic [127:0] REQ_ADDR;
  logic [11:0]  REQ_BURSTCOUNT;
  logic [3:0]   REQ_WRITE;
  logic [127:0] REQ_WRITEDATA;
  logic [15:0]  REQ_BYTEENABLE;
  logic [3:0]   REQ_WAITREQUEST;
  logic [31:0]  AM_ADDR;
  logic [2:0]   AM_BURSTCOUNT;
  logic         AM_WRITE;
  logic [31:0]  AM_WRITEDATA;
  logic [3:0]   AM_BYTEENABLE;
  logic         AM_WAITREQUEST;
  logic [3:0]   GRANT;
  logic         BUSY;

  // three-channel instance for the non-power-of-two wrap
  logic [2:0]   c3_enable;
  logic [95:0]  c3_addr;
  logic [8:0]   c3_bc;
  logic [2:0]   c3_write;
  logic [95:0]  c3_wdata;
  logic [11:0]  c3_be;
  logic [2:0]   c3_waitreq;
  logic [31:0]  c3_am_addr;
  logic [2:0]   c3_am_bc;
  logic         c3_am_write;
  logic [31:0]  c3_am_wdata;
  logic [3:0]   c3_am_be;
  logic         c3_am_waitreq;
  logic [2:0]   c3_grant;
  logic         c3_busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mic_dma_arbiter #(.N_REQ(4), .BURST_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .CH_ENABLE(CH_ENABLE),
    .REQ_ADDR(REQ_ADDR), .REQ_BURSTCOUNT(REQ_BURSTCOUNT), .REQ_WRITE(REQ_WRITE),
    .REQ_WRITEDATA(REQ_WRITEDATA), .REQ_BYTEENABLE(REQ_BYTEENABLE),
    .REQ_WAITREQUEST(REQ_WAITREQUEST),
    .AM_ADDR(AM_ADDR), .AM_BURSTCOUNT(AM_BURSTCOUNT), .AM_WRITE(AM_WRITE),
    .AM_WRITEDATA(AM_WRITEDATA), .AM_BYTEENABLE(AM_BYTEENABLE),
    .AM_WAITREQUEST(AM_WAITREQUEST), .GRANT(GRANT), .BUSY(BUSY)
  );

  mic_dma_arbiter #(.N_REQ(3), .BURST_W(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .CH_ENABLE(c3_enable),
    .REQ_ADDR(c3_addr), .REQ_BURSTCOUNT(c3_bc), .REQ_WRITE(c3_write),
    .REQ_WRITEDATA(c3_wdata), .REQ_BYTEENABLE(c3_be),
    .REQ_WAITREQUEST(c3_waitreq),
    .AM_ADDR(c3_am_addr), .AM_BURSTCOUNT(c3_am_bc), .AM_WRITE(c3_am_write),
    .AM_WRITEDATA(c3_am_wdata), .AM_BYTEENABLE(c3_am_be),
    .AM_WAITREQUEST(c3_am_waitreq), .GRANT(c3_grant), .BUSY(c3_busy)
  );

  task automatic set_ch(input int i, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] bc, input logic [3:0] be);
    REQ_ADDR[i*32 +: 32]      = addr;
    REQ_WRITEDATA[i*32 +: 32] = data;
    REQ_BURSTCOUNT[i*3 +: 3]  = bc;
    REQ_BYTEENABLE[i*4 +: 4]  = be;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    CH_ENABLE = 4'hF; REQ_ADDR = '0; REQ_BURSTCOUNT = '0; REQ_WRITE = '0;
    REQ_WRITEDATA = '0; REQ_BYTEENABLE = '0; AM_WAITREQUEST = 1'b0;
    c3_enable = '0; c3_addr = '0; c3_bc = '0; c3_write = '0; c3_wdata = '0;
    c3_be = '0; c3_am_waitreq = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    REQ_ADDR = {4{32'hDEAD_0000}}; REQ_WRITEDATA = {4{32'h1234_5678}};
    REQ_BURSTCOUNT = {4{3'd5}}; REQ_BYTEENABLE = 16'hFFFF; REQ_WRITE = 4'hF;
    #1;
    checks++;
    if ({GRANT, BUSY, AM_WRITE, REQ_WAITREQUEST, c3_grant} !== {4'h0, 1'b0, 1'b0, 4'hF, 3'b000}) begin
      errors++;
      $display("FAIL reset_ctrl: got grant=%b busy=%b wr=%b wreq=%b g3=%b want 0000 0 0 1111 000",
               GRANT, BUSY, AM_WRITE, REQ_WAITREQUEST, c3_grant);
    end
    checks++;
    if ({AM_ADDR, AM_BURSTCOUNT, AM_WRITEDATA, AM_BYTEENABLE} !== 71'd0) begin
      errors++;
      $display("FAIL reset_am_zero: got addr=%h bc=%0d data=%h be=%h want all 0",
               AM_ADDR, AM_BURSTCOUNT, AM_WRITEDATA, AM_BYTEENABLE);
    end
    // out of reset with data on the channels but nobody writing: stays idle
    REQ_WRITE = 4'h0;
    @(negedge CLK); RESET = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({GRANT, BUSY, AM_ADDR, AM_WRITEDATA, REQ_WAITREQUEST} !== {4'h0, 1'b0, 32'h0, 32'h0, 4'hF}) begin
      errors++;
      $display("FAIL idle_no_req: got grant=%b busy=%b addr=%h data=%h wreq=%b want 0 0 0 0 1111",
               GRANT, BUSY, AM_ADDR, AM_WRITEDATA, REQ_WAITREQUEST);
    end
  endtask

  task automatic test_single_burst();
    int beat, stall, guard;
    do_reset();
    @(negedge CLK);
    set_ch(0, 32'h1000, 32'hA0, 3'd4, 4'hF);
    REQ_WRITE = 4'b0001;
    #1;
    checks++;
    if (GRANT !== 4'h0) begin
      errors++; $display("FAIL sb_pre_grant: got %b want 0000", GRANT);
    end
    beat = 0; stall = 0; guard = 0;
    while (beat < 4 && guard < 20) begin
      @(negedge CLK);
      guard++;
      REQ_WRITEDATA[31:0] = 32'hA0 + beat;
      AM_WAITREQUEST = (beat == 1 && stall < 2);
      #1;
      checks++;
      if ({GRANT, BUSY, AM_WRITE, AM_ADDR, AM_BURSTCOUNT, AM_BYTEENABLE} !==
          {4'b0001, 1'b1, 1'b1, 32'h1000, 3'd4, 4'hF}) begin
        errors++;
        $display("FAIL sb_ctrl beat %0d: got grant=%b busy=%b wr=%b addr=%h bc=%0d be=%h want 0001 1 1 1000 4 f",
                 beat, GRANT, BUSY, AM_WRITE, AM_ADDR, AM_BURSTCOUNT, AM_BYTEENABLE);
      end
      checks++;
      if ({AM_WRITEDATA, REQ_WAITREQUEST} !== {32'hA0 + beat, 3'b111, AM_WAITREQUEST}) begin
        errors++;
        $display("FAIL sb_data beat %0d: got data=%h wreq=%b want data=%h wreq=111%b",
                 beat, AM_WRITEDATA, REQ_WAITREQUEST, 32'hA0 + beat, AM_WAITREQUEST);
      end
      if (AM_WAITREQUEST) stall++; else beat++;
    end
    checks++;
    if (beat != 4 || stall != 2) begin
      errors++; $display("FAIL sb_timeout: got beats=%0d stalls=%0d want 4 2", beat, stall);
    end
    AM_WAITREQUEST = 1'b0;
    // ch0 still asks, but having just been served it loses to ch1
    @(negedge CLK);
    set_ch(1, 32'h2000, 32'hB0, 3'd1, 4'h3);
    REQ_WRITE = 4'b0011;
    #1;
    checks++;
    if ({GRANT, BUSY, AM_WRITE, REQ_WAITREQUEST} !== {4'h0, 1'b0, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL sb_end_idle: got grant=%b busy=%b wr=%b wreq=%b want 0000 0 0 1111",
               GRANT, BUSY, AM_WRITE, REQ_WAITREQUEST);
    end
    @(negedge CLK); #1;
    checks++;
    if ({GRANT, AM_ADDR, AM_BYTEENABLE, AM_WRITEDATA} !== {4'b0010, 32'h2000, 4'h3, 32'hB0}) begin
      errors++;
      $display("FAIL sb_ptr_next: got grant=%b addr=%h be=%h data=%h want 0010 2000 3 b0",
               GRANT, AM_ADDR, AM_BYTEENABLE, AM_WRITEDATA);
    end
    @(negedge CLK); REQ_WRITE = 4'h0; #1;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL sb_single_beat_end: got busy=%b want 0", BUSY);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 1, 3, 0, 1, 3};
    int n, guard, idle_run, busy_run, idx;
    logic [3:0] prev;
    do_reset();
    @(negedge CLK);
    set_ch(0, 32'h100, 32'h10, 3'd2, 4'hF);
    set_ch(1, 32'h200, 32'h20, 3'd2, 4'hF);
    set_ch(2, 32'h300, 32'h30, 3'd2, 4'hF);
    set_ch(3, 32'h400, 32'h40, 3'd2, 4'hF);
    CH_ENABLE = 4'hF;
    REQ_WRITE = 4'b1011;
    prev = 4'h0; n = 0; guard = 0; idle_run = 0; busy_run = 0;
    while (n < 6 && guard < 40) begin
      @(negedge CLK); #1;
      guard++;
      if (GRANT !== 4'h0 && prev === 4'h0) begin
        idx = -1;
        for (int i = 0; i < 4; i++) if (GRANT[i]) idx = i;
        checks++;
        if (idx != exp_order[n] || !$onehot(GRANT)) begin
          errors++;
          $display("FAIL rr_order #%0d: got grant=%b want ch%0d", n, GRANT, exp_order[n]);
        end
        if (n > 0) begin
          checks++;
          if (idle_run != 1) begin
            errors++; $display("FAIL rr_gap #%0d: got %0d idle cycles want 1", n, idle_run);
          end
        end
        n++;
        idle_run = 0;
        busy_run = 0;
      end
      if (GRANT === 4'h0 && prev !== 4'h0) begin
        checks++;
        if (busy_run != 2) begin
          errors++; $display("FAIL rr_burst_len: got %0d busy cycles want 2", busy_run);
        end
      end
      if (GRANT === 4'h0) idle_run++; else busy_run++;
      checks++;
      if (GRANT[2] !== 1'b0) begin
        errors++; $display("FAIL rr_ch2: got grant=%b want bit2 0", GRANT);
      end
      prev = GRANT;
    end
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL rr_timeout: got %0d grants want 6", n);
    end
    REQ_WRITE = 4'h0;
  endtask

  task automatic test_mask();
    do_reset();
    @(negedge CLK);
    CH_ENABLE = 4'b1101;
    set_ch(0, 32'h3000, 32'h50, 3'd4, 4'hF);
    set_ch(1, 32'h3100, 32'h60, 3'd2, 4'hF);
    REQ_WRITE = 4'b0010;
    repeat (4) begin
      @(negedge CLK); #1;
      checks++;
      if ({GRANT, REQ_WAITREQUEST} !== {4'h0, 4'hF}) begin
        errors++; $display("FAIL mask_blocked: got grant=%b wreq=%b want 0000 1111", GRANT, REQ_WAITREQUEST);
      end
    end
    @(negedge CLK); REQ_WRITE = 4'b0011; #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (c == 1) CH_ENABLE = 4'b1100;
      #1;
      checks++;
      if ({GRANT, BUSY, AM_ADDR} !== {4'b0001, 1'b1, 32'h3000}) begin
        errors++;
        $display("FAIL mask_midburst cyc %0d: got grant=%b busy=%b addr=%h want 0001 1 3000",
                 c, GRANT, BUSY, AM_ADDR);
      end
    end
    @(negedge CLK); REQ_WRITE = 4'b0010; #1;
    checks++;
    if ({GRANT, BUSY} !== {4'h0, 1'b0}) begin
      errors++; $display("FAIL mask_done: got grant=%b busy=%b want 0000 0", GRANT, BUSY);
    end
    @(negedge CLK); CH_ENABLE = 4'b1110; #1;
    checks++;
    if (GRANT !== 4'h0) begin
      errors++; $display("FAIL mask_still_idle: got grant=%b want 0000", GRANT);
    end
    @(negedge CLK); #1;
    checks++;
    if ({GRANT, AM_ADDR} !== {4'b0010, 32'h3100}) begin
      errors++; $display("FAIL mask_enable_grant: got grant=%b addr=%h want 0010 3100", GRANT, AM_ADDR);
    end
    @(negedge CLK); #1;
    @(negedge CLK); REQ_WRITE = 4'h0; #1;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL mask_ch1_end: got busy=%b want 0", BUSY);
    end
  endtask

  task automatic test_idle_beats();
    do_reset();
    @(negedge CLK);
    set_ch(2, 32'h4000, 32'hC0, 3'd3, 4'hF);
    REQ_WRITE = 4'b0100;
    @(negedge CLK); #1;
    checks++;
    if ({GRANT, AM_WRITE, AM_WRITEDATA, AM_BURSTCOUNT} !== {4'b0100, 1'b1, 32'hC0, 3'd3}) begin
      errors++;
      $display("FAIL ib_beat1: got grant=%b wr=%b data=%h bc=%0d want 0100 1 c0 3",
               GRANT, AM_WRITE, AM_WRITEDATA, AM_BURSTCOUNT);
    end
    repeat (5) begin
      @(negedge CLK); REQ_WRITE = 4'h0; #1;
      checks++;
      if ({GRANT, BUSY, AM_WRITE, REQ_WAITREQUEST} !== {4'b0100, 1'b1, 1'b0, 4'b1011}) begin
        errors++;
        $display("FAIL ib_hold: got grant=%b busy=%b wr=%b wreq=%b want 0100 1 0 1011",
                 GRANT, BUSY, AM_WRITE, REQ_WAITREQUEST);
      end
    end
    @(negedge CLK); REQ_WRITE = 4'b0100; REQ_WRITEDATA[95:64] = 32'hC1; #1;
    @(negedge CLK); REQ_WRITEDATA[95:64] = 32'hC2; #1;
    checks++;
    if ({GRANT, AM_WRITE, AM_WRITEDATA} !== {4'b0100, 1'b1, 32'hC2}) begin
      errors++; $display("FAIL ib_beat3: got grant=%b wr=%b data=%h want 0100 1 c2", GRANT, AM_WRITE, AM_WRITEDATA);
    end
    @(negedge CLK); REQ_BURSTCOUNT[8:6] = 3'd0; #1;
    checks++;
    if ({GRANT, BUSY} !== {4'h0, 1'b0}) begin
      errors++; $display("FAIL ib_end: got grant=%b busy=%b want 0000 0", GRANT, BUSY);
    end
    @(negedge CLK); #1;
    checks++;
    if ({GRANT, AM_BURSTCOUNT, AM_WRITE} !== {4'b0100, 3'd0, 1'b1}) begin
      errors++; $display("FAIL bc0_grant: got grant=%b bc=%0d wr=%b want 0100 0 1", GRANT, AM_BURSTCOUNT, AM_WRITE);
    end
    @(negedge CLK); REQ_WRITE = 4'h0; #1;
    checks++;
    if ({GRANT, BUSY} !== {4'h0, 1'b0}) begin
      errors++; $display("FAIL bc0_one_beat: got grant=%b busy=%b want 0000 0", GRANT, BUSY);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    @(negedge CLK);
    set_ch(0, 32'h5000, 32'hD0, 3'd1, 4'hF);
    REQ_WRITE = 4'b0001;
    @(negedge CLK); #1;
    @(negedge CLK);
    set_ch(0, 32'h5000, 32'hD0, 3'd4, 4'hF);
    set_ch(1, 32'h6000, 32'hE0, 3'd4, 4'hF);
    REQ_WRITE = 4'b0011;
    @(negedge CLK); #1;
    checks++;
    if (GRANT !== 4'b0010) begin
      errors++; $display("FAIL rst_pre_grant: got grant=%b want 0010", GRANT);
    end
    @(negedge CLK); #1;
    #2; RESET = 1'b0; #1;
    checks++;
    if ({AM_WRITE, GRANT, BUSY, REQ_WAITREQUEST, AM_ADDR} !== {1'b0, 4'h0, 1'b0, 4'hF, 32'h0}) begin
      errors++;
      $display("FAIL rst_async: got wr=%b grant=%b busy=%b wreq=%b addr=%h want 0 0000 0 1111 0",
               AM_WRITE, GRANT, BUSY, REQ_WAITREQUEST, AM_ADDR);
    end
    @(negedge CLK); RESET = 1'b1; #1;
    @(negedge CLK); #1;
    checks++;
    if ({GRANT, AM_ADDR} !== {4'b0001, 32'h5000}) begin
      errors++; $display("FAIL rst_restart_ch0: got grant=%b addr=%h want 0001 5000", GRANT, AM_ADDR);
    end
  endtask

  task automatic test_contention_n3();
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    int n, guard, idx;
    logic [2:0] prev;
    do_reset();
    @(negedge CLK);
    c3_enable = 3'b111;
    c3_bc = {3'd1, 3'd1, 3'd1};
    c3_addr = {32'h7200, 32'h7100, 32'h7000};
    c3_write = 3'b111;
    prev = 3'b000; n = 0; guard = 0;
    while (n < 6 && guard < 40) begin
      @(negedge CLK); #1;
      guard++;
      checks++;
      if (!$onehot0(c3_grant)) begin
        errors++; $display("FAIL n3_onehot: got grant=%b want at most one bit", c3_grant);
      end
      if (c3_grant !== 3'b000 && prev === 3'b000) begin
        idx = -1;
        for (int i = 0; i < 3; i++) if (c3_grant[i]) idx = i;
        checks++;
        if (idx != exp_order[n] || c3_am_addr !== 32'h7000 + 32'h100 * exp_order[n]) begin
          errors++;
          $display("FAIL n3_order #%0d: got grant=%b addr=%h want ch%0d", n, c3_grant, c3_am_addr, exp_order[n]);
        end
        n++;
      end
      prev = c3_grant;
    end
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL n3_timeout: got %0d grants want 6", n);
    end
    c3_write = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_mask();
    test_idle_beats();
    test_reset_mid_burst();
    test_contention_n3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_dma_arbiter.md
# mic_dma_arbiter

Round-robin write arbiter that shares one Avalon-MM burst-write master port between `N_REQ` microphone DMA channels. Each channel presents a standard Avalon-MM burst-write master interface. The arbiter grants the shared port to one channel for a whole burst and forwards `AM_WAITREQUEST` to that channel only. It sits between the per-channel mic DMA engines and the SDRAM/HPS bridge port. Channels are gated by a software-written enable mask.

## Interface
- `N_REQ`, 4, number of requesting DMA channels (2..8)
- `BURST_W`, 3, burstcount width
- `CLK` in 1: system clock; all logic on rising edge
- `RESET` in 1: asynchronous, active-low reset
- `CH_ENABLE` in `N_REQ`: per-channel grant enable (1 = eligible)
- `REQ_ADDR` in `N_REQ*32`: channel i at `[32i+31:32i]`
- `REQ_BURSTCOUNT` in `N_REQ*BURST_W`: channel i burst length, sampled at grant
- `REQ_WRITE` in `N_REQ`: channel write request / beat valid
- `REQ_WRITEDATA` in `N_REQ*32`: channel write data
- `REQ_BYTEENABLE` in `N_REQ*4`: channel byte enables
- `REQ_WAITREQUEST` out `N_REQ`: per-channel waitrequest
- `AM_ADDR` out 32: shared master address
- `AM_BURSTCOUNT` out `BURST_W`: shared master burstcount
- `AM_WRITE` out 1: shared master write
- `AM_WRITEDATA` out 32: shared master write data
- `AM_BYTEENABLE` out 4: shared master byte enables
- `AM_WAITREQUEST` in 1: slave waitrequest
- `GRANT` out `N_REQ`: one-hot current grant; 0 in IDLE
- `BUSY` out 1: 1 while in BURST

## Operation
- States: IDLE and BURST.
- **IDLE**
  - Eligible channels are those with `REQ_WRITE[i] & CH_ENABLE[i]`.
  - If any channel is eligible, select the first one at or after `ptr`, searching in increasing index order with wrap at `N_REQ`.
  - Register `GRANT` to that channel, load `beats` from its `REQ_BURSTCOUNT`, and go to BURST.
  - If no channel is eligible, stay in IDLE.
- **BURST**
  - Drive `AM_*` combinationally from the granted channel's `REQ_*`.
  - `REQ_WAITREQUEST[g] = AM_WAITREQUEST`.
  - An accepted beat is `AM_WRITE & ~AM_WAITREQUEST`. Each accepted beat decrements `beats`.
  - When the accepted beat is made with `beats == 1`, go to IDLE, clear `GRANT`, and set `ptr = (g+1) mod N_REQ`.
- **Waitrequest for other channels**
  - In all states, `REQ_WAITREQUEST[i] = 1` for every i not currently granted.
  - In IDLE, all `REQ_WAITREQUEST` bits are 1.
- **Master outputs in IDLE**
  - `AM_WRITE = 0`.
  - `AM_ADDR`, `AM_BURSTCOUNT`, `AM_WRITEDATA` and `AM_BYTEENABLE` are all 0.
- **Idle beats:** the granted channel may drop `REQ_WRITE` mid-burst. The grant is held until all beats are accepted; there is no timeout.
- **Burstcount 0:** a `REQ_BURSTCOUNT` of 0 at grant is loaded as 1. `AM_BURSTCOUNT` still forwards the channel's raw value.
- **Mask changes:** changes to `CH_ENABLE` affect only the next arbitration. The current burst always completes.
- **Width rules:**
  - `beats` is `BURST_W` bits wide.
  - `ptr` is `clog2(N_REQ)` bits wide and wraps explicitly at `N_REQ`, not at a power of 2.

## Timing
- **Reset (asynchronous, `RESET=0`):**
  - State IDLE, `ptr = 0`, `GRANT = 0`, `BUSY = 0`, `beats = 0`.
  - `AM_WRITE = 0`, all `AM_*` outputs are 0, all `REQ_WAITREQUEST` bits are 1.
  - Reset taken mid-burst abandons the burst immediately. The downstream slave is assumed reset in the same domain.
- **Grant latency:**
  - Request seen in IDLE at edge k: `GRANT` and `BUSY` are valid after edge k.
  - The first `AM_WRITE` is visible in cycle k+1.
  - The granted channel's `REQ_WAITREQUEST` follows `AM_WAITREQUEST` from that same cycle.
- **Burst boundaries:**
  - The last accepted beat at edge m puts the block in IDLE after edge m.
  - The earliest next grant is at edge m+1, giving a minimum one-cycle bubble between bursts.
- **Throughput:** a burst of B beats with no stalls occupies B BURST cycles plus 1 IDLE cycle.
- **Simultaneous requests:** resolved purely by `ptr` priority. A channel that was just served drops to lowest priority.

## Test plan
- **Single burst with stalls:** ch0 requests with burstcount 4, `ADDR=0x1000`; `AM_WAITREQUEST` high on the 2nd beat for 2 cycles.
  - `AM_ADDR=0x1000` and `AM_BURSTCOUNT=4`.
  - Exactly 4 accepted beats with data in order.
  - `REQ_WAITREQUEST[0]` mirrors the slave.
  - IDLE after the 4th beat, then `ptr=1`.
- **Round robin:** ch0, ch1 and ch3 request continuously with burstcount 2, `CH_ENABLE=4'b1111`.
  - Grant order is 0, 1, 3, 0, 1, 3.
  - A one-cycle IDLE gap between bursts.
  - ch2 never granted.
- **Mask:** ch1 requests with `CH_ENABLE=4'b1101`.
  - No grant while masked.
  - Clearing the mask mid-burst of ch0 does not abort it.
  - Setting bit1 yields a grant to ch1 on the next IDLE cycle.
- **Idle beats and burstcount 0:**
  - Granted ch2 (burstcount 3) drops `REQ_WRITE` for 5 cycles after beat 1. The grant is held and the burst completes after 3 accepted beats.
  - ch2 with burstcount 0 completes after 1 beat.
- **Reset mid-burst:** assert `RESET=0` during beat 2 of 4.
  - Asynchronously: `AM_WRITE=0`, `GRANT=0`, all `REQ_WAITREQUEST` bits 1.
  - After release, arbitration restarts from ch0.
- **Contention when N_REQ=3:** all three channels request.
  - `ptr` wraps 2 → 0.
  - Never-selected index 3 does not appear.
